// File: rtl/gamecube_word_transmitter_if.sv
// Host-side bundle for the GameCube word transmitter.
// Host drives i_start/i_data/i_len/i_stop_en. The transmitter returns
// o_dataline/o_busy/o_done.
//   slave  : transmitter side (takes the request, drives the line)
//   master : host side
interface gamecube_word_transmitter_if #(
  parameter  int WORD_BITS = 24,
  localparam int LEN_W     = $clog2(WORD_BITS + 1)
);
  logic                 i_start;
  logic [WORD_BITS-1:0] i_data;
  logic [LEN_W-1:0]     i_len;
  logic                 i_stop_en;
  logic                 o_dataline;
  logic                 o_busy;
  logic                 o_done;

  modport slave (
    input  i_start, i_data, i_len, i_stop_en,
    output o_dataline, o_busy, o_done
  );

  modport master (
    output i_start, i_data, i_len, i_stop_en,
    input  o_dataline, o_busy, o_done
  );
endinterface

// File: rtl/gamecube_word_transmitter.sv
// Serialises a variable-length word onto the GameCube DATALINE, MSB first.
// Every bit is a 4-slot cell: low / bit / bit / high. An optional stop bit
// can be appended, and it is sent as a '1' cell. Each slot lasts
// QUARTER_CYCLES clocks.
// Ports:
//   i_clk  : system clock, rising edge
//   i_rst  : synchronous reset, active high
//   bus    : request (start/data/len/stop_en) in; dataline/busy/done out
module gamecube_word_transmitter #(
  parameter  int WORD_BITS      = 24,
  parameter  int QUARTER_CYCLES = 1,
  localparam int LEN_W          = $clog2(WORD_BITS + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  gamecube_word_transmitter_if.slave    bus
);
  localparam int              QW      = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
  localparam logic [QW-1:0]   Q_LAST  = QW'(QUARTER_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WORD_BITS);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;

  state_t               r_state,    w_state_n;
  logic [QW-1:0]        r_qcnt,     w_qcnt_n;
  logic [1:0]           r_slot,     w_slot_n;
  logic [LEN_W-1:0]     r_bits,     w_bits_n;
  logic [WORD_BITS-1:0] r_shift,    w_shift_n;
  logic                 r_stop_en,  w_stop_n;
  logic                 r_dataline, w_line_n;
  logic                 r_busy,     w_busy_n;
  logic                 r_done,     w_done_n;

  logic [LEN_W-1:0]     w_len_c;
  logic                 w_bit;
  logic                 w_slot_end;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_qcnt     <= '0;
      r_slot     <= '0;
      r_bits     <= '0;
      r_shift    <= '0;
      r_stop_en  <= 1'b0;
      r_dataline <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_qcnt     <= w_qcnt_n;
      r_slot     <= w_slot_n;
      r_bits     <= w_bits_n;
      r_shift    <= w_shift_n;
      r_stop_en  <= w_stop_n;
      r_dataline <= w_line_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
    end
  end

  assign w_len_c    = (bus.i_len > LEN_MAX) ? LEN_MAX : bus.i_len;
  // The stop cell has the same waveform as a data '1'.
  assign w_bit      = (r_state == S_STOP) | r_shift[WORD_BITS-1];
  assign w_slot_end = (r_qcnt == Q_LAST);

  // The outputs are registered, so the logic below works out the line level
  // for the slot that is about to begin.
  always_comb begin
    w_state_n = r_state;
    w_qcnt_n  = r_qcnt;
    w_slot_n  = r_slot;
    w_bits_n  = r_bits;
    w_shift_n = r_shift;
    w_stop_n  = r_stop_en;
    w_line_n  = r_dataline;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_shift_n = bus.i_data;
          w_bits_n  = w_len_c;
          w_stop_n  = bus.i_stop_en;
          w_qcnt_n  = '0;
          w_slot_n  = '0;
          if (w_len_c != '0) begin
            w_state_n = S_DATA;
            w_line_n  = 1'b0;
            w_busy_n  = 1'b1;
          end else if (bus.i_stop_en) begin
            w_state_n = S_STOP;
            w_line_n  = 1'b0;
            w_busy_n  = 1'b1;
          end else begin
            // An empty frame never occupies the line; it only reports completion.
            w_done_n  = 1'b1;
          end
        end
      end
      S_DATA, S_STOP: begin
        if (!w_slot_end) begin
          w_qcnt_n = r_qcnt + QW'(1);
        end else begin
          w_qcnt_n = '0;
          w_slot_n = r_slot + 2'd1;
          unique case (r_slot)
            2'd0, 2'd1: w_line_n = w_bit;
            2'd2:       w_line_n = 1'b1;
            default: begin
              // The cell is complete. Continue with the next data bit, the
              // stop bit, or finish the frame.
              w_line_n = 1'b0;
              if (r_state == S_DATA && r_bits != LEN_W'(1)) begin
                w_shift_n = r_shift << 1;
                w_bits_n  = r_bits - LEN_W'(1);
              end else if (r_state == S_DATA && r_stop_en) begin
                w_bits_n  = '0;
                w_state_n = S_STOP;
              end else begin
                w_bits_n  = '0;
                w_state_n = S_IDLE;
                w_line_n  = 1'b1;
                w_busy_n  = 1'b0;
                w_done_n  = 1'b1;
              end
            end
          endcase
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_line_n  = 1'b1;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.o_dataline = r_dataline;
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
endmodule
